// File: rtl/csa_iter_multiplier_if.sv
// Issue/result handshake bundle for the iterative carry-save multiplier.
// The bench or reservation station takes the master side; the multiplier takes the slave side.
interface csa_iter_multiplier_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [TAG_W-1:0]     out_tag;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_product, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, flush, out_ready,
    output in_ready, out_valid, out_product, out_tag, busy
  );
endinterface

// File: rtl/csa_iter_multiplier.sv
// Iterative multiplier: BITS_PER_CYCLE partial products per clock folded into a redundant
// sum/carry pair by chained 3:2 rows, then one carry-propagate add with sign fix-up.
module csa_iter_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int TAG_W          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  csa_iter_multiplier_if.slave   bus
);
  localparam int PW    = 2 * WIDTH;
  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESOLVE, DONE} state_t;

  state_t             state;
  logic [PW-1:0]      sum;
  logic [PW-1:0]      carry;
  logic [PW-1:0]      mcand_sh;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg;
  logic [TAG_W-1:0]   tag;
  logic               out_valid_q;
  logic [PW-1:0]      product_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [PW-1:0]      next_sum;
  logic [PW-1:0]      next_carry;
  logic [PW-1:0]      pp;
  logic [PW-1:0]      row_sum;
  logic [PW-1:0]      raw_product;
  logic [PW-1:0]      resolved;

  assign mag_a = (bus.in_signed && bus.in_a[WIDTH-1]) ? (~bus.in_a + WIDTH'(1)) : bus.in_a;
  assign mag_b = (bus.in_signed && bus.in_b[WIDTH-1]) ? (~bus.in_b + WIDTH'(1)) : bus.in_b;

  // mcand_sh already carries the count*BITS_PER_CYCLE offset, so row i only adds i more
  always_comb begin
    next_sum   = sum;
    next_carry = carry;
    pp         = '0;
    row_sum    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pp         = mplier[i] ? (mcand_sh << i) : '0;
      row_sum    = next_sum ^ next_carry ^ pp;
      next_carry = ((next_sum & next_carry) | (next_sum & pp) | (next_carry & pp)) << 1;
      next_sum   = row_sum;
    end
  end

  assign raw_product = sum + carry;
  assign resolved    = neg ? (~raw_product + PW'(1)) : raw_product;

  assign bus.in_ready    = (state == IDLE) && !bus.flush;
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = product_q;
  assign bus.out_tag     = out_tag_q;

  // Flush outranks both accept and CDB grant; result registers keep their last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sum         <= '0;
      carry       <= '0;
      mcand_sh    <= '0;
      mplier      <= '0;
      count       <= '0;
      neg         <= 1'b0;
      tag         <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      out_tag_q   <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_sh <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            neg      <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
            tag      <= bus.in_tag;
            sum      <= '0;
            carry    <= '0;
            count    <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          sum      <= next_sum;
          carry    <= next_carry;
          mplier   <= mplier >> BITS_PER_CYCLE;
          mcand_sh <= mcand_sh << BITS_PER_CYCLE;
          count    <= count + CW'(1);
          if (count == CW'(ITERS - 1)) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          product_q   <= resolved;
          out_tag_q   <= tag;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_iter_multiplier.sv
// Randomised and directed bench for csa_iter_multiplier: default instance plus
// BITS_PER_CYCLE=1 and 8 instances, all checked against a plain-arithmetic product model.
module tb_csa_iter_multiplier;
  localparam int LAT[3] = '{9, 33, 5};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic        s_drv = 1'b0;
  logic [3:0]  tag_drv = '0;
  logic        valid_drv = 1'b0;
  logic        aux_en = 1'b0;
  logic        flush_drv = 1'b0;
  logic        ready_drv = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_iter_multiplier_if #(.WIDTH(32), .TAG_W(4)) m_if ();
  csa_iter_multiplier_if #(.WIDTH(32), .TAG_W(4)) s1_if ();
  csa_iter_multiplier_if #(.WIDTH(32), .TAG_W(4)) s8_if ();

  assign m_if.in_valid   = valid_drv;
  assign m_if.in_a       = a_drv;
  assign m_if.in_b       = b_drv;
  assign m_if.in_signed  = s_drv;
  assign m_if.in_tag     = tag_drv;
  assign m_if.flush      = flush_drv;
  assign m_if.out_ready  = ready_drv;

  assign s1_if.in_valid  = valid_drv & aux_en;
  assign s1_if.in_a      = a_drv;
  assign s1_if.in_b      = b_drv;
  assign s1_if.in_signed = s_drv;
  assign s1_if.in_tag    = tag_drv;
  assign s1_if.flush     = flush_drv;
  assign s1_if.out_ready = ready_drv;

  assign s8_if.in_valid  = valid_drv & aux_en;
  assign s8_if.in_a      = a_drv;
  assign s8_if.in_b      = b_drv;
  assign s8_if.in_signed = s_drv;
  assign s8_if.in_tag    = tag_drv;
  assign s8_if.flush     = flush_drv;
  assign s8_if.out_ready = ready_drv;

  csa_iter_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4), .TAG_W(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(m_if));
  csa_iter_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1), .TAG_W(4)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(s1_if));
  csa_iter_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(8), .TAG_W(4)) dut_8 (.clk(clk), .rst_n(rst_n), .bus(s8_if));

  logic        ov[3];
  logic [63:0] prod[3];
  logic [3:0]  otag[3];
  assign ov[0] = m_if.out_valid;   assign prod[0] = m_if.out_product;   assign otag[0] = m_if.out_tag;
  assign ov[1] = s1_if.out_valid;  assign prod[1] = s1_if.out_product;  assign otag[1] = s1_if.out_tag;
  assign ov[2] = s8_if.out_valid;  assign prod[2] = s8_if.out_product;  assign otag[2] = s8_if.out_tag;

  function automatic logic [63:0] refProduct(logic [31:0] a, logic [31:0] b, logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One op through all three instances; operands are scrambled right after the accept edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
    logic [63:0] exp;
    bit          seen[3];
    exp = refProduct(a, b, s);
    seen = '{0, 0, 0};
    a_drv = a; b_drv = b; s_drv = s; tag_drv = t;
    aux_en = 1'b1; ready_drv = 1'b1; valid_drv = 1'b1;
    @(posedge clk); #1;
    valid_drv = 1'b0;
    a_drv = $urandom; b_drv = $urandom; s_drv = ~s; tag_drv = ~t;
    for (int k = 1; k <= 40 && !(seen[0] && seen[1] && seen[2]); k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        if (!seen[j] && ov[j]) begin
          seen[j] = 1;
          checkOutput($sformatf("latency%0d", j), 64'(k), 64'(LAT[j]));
          checkOutput($sformatf("product%0d a=%h b=%h s=%0d", j, a, b, s), prod[j], exp);
          checkOutput($sformatf("tag%0d", j), 64'(otag[j]), 64'(t));
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (!seen[j]) checkOutput($sformatf("timeout%0d", j), 64'(0), 64'(1));
    end
    @(posedge clk); #1;
    aux_en = 1'b0;
  endtask

  task automatic waitMainValid(output int k);
    k = 0;
    while (!m_if.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic expectNoResult(input string name, input int n);
    int hits = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (m_if.out_valid) hits++;
    end
    checkOutput(name, 64'(hits), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          k;
    int          idx;
    int          last_acc;
    int          nout;
    logic [63:0] q_prod[$];
    logic [3:0]  q_tag[$];
    logic [31:0] ta[3];
    logic [31:0] tb_[3];
    logic        ts[3];
    logic [63:0] ep;
    logic [3:0]  et;
    bit          acc;

    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_out_valid", 64'(m_if.out_valid), 64'(0));
    checkOutput("reset_product", m_if.out_product, 64'(0));
    checkOutput("reset_tag", 64'(m_if.out_tag), 64'(0));
    checkOutput("reset_busy", 64'(m_if.busy), 64'(0));
    checkOutput("reset_in_ready", 64'(m_if.in_ready), 64'(1));

    // Result held under back-pressure, then released by the grant
    a_drv = 32'hFFFFFFFF; b_drv = 32'hFFFFFFFF; s_drv = 1'b0; tag_drv = 4'd5;
    ready_drv = 1'b0; valid_drv = 1'b1;
    @(posedge clk); #1;
    valid_drv = 1'b0;
    waitMainValid(k);
    checkOutput("hold_latency", 64'(k), 64'(9));
    checkOutput("hold_product", m_if.out_product, 64'hFFFFFFFE00000001);
    checkOutput("hold_tag", 64'(m_if.out_tag), 64'(5));
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 64'(m_if.out_valid), 64'(1));
      checkOutput("hold_product_stable", m_if.out_product, 64'hFFFFFFFE00000001);
    end
    ready_drv = 1'b1;
    @(posedge clk); #1;
    checkOutput("grant_clears_valid", 64'(m_if.out_valid), 64'(0));
    checkOutput("grant_in_ready", 64'(m_if.in_ready), 64'(1));

    applyStimulus(32'h80000000, 32'h80000000, 1'b1, 4'd1);
    applyStimulus(32'hFFFFFFFF, 32'h00000007, 1'b1, 4'd2);
    applyStimulus(32'h80000000, 32'h00000001, 1'b1, 4'd3);
    applyStimulus(32'hFFFFFFFE, 32'h00000002, 1'b0, 4'd4);
    applyStimulus(32'hFFFFFFFE, 32'h00000002, 1'b1, 4'd6);
    applyStimulus(32'h00000000, 32'hDEADBEEF, 1'b1, 4'd7);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd8);

    // Flush while iterating
    a_drv = 32'd1234; b_drv = 32'd5678; s_drv = 1'b0; tag_drv = 4'd10; valid_drv = 1'b1;
    @(posedge clk); #1;
    valid_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush_drv = 1'b1;
    @(posedge clk); #1;
    checkOutput("flush_busy_idle", 64'(m_if.busy), 64'(0));
    checkOutput("flush_blocks_ready", 64'(m_if.in_ready), 64'(0));
    flush_drv = 1'b0;
    #1;
    checkOutput("flush_busy_ready", 64'(m_if.in_ready), 64'(1));
    expectNoResult("flush_busy_noresult", 12);

    // Flush in DONE beats the grant; result registers keep their contents
    a_drv = 32'd3; b_drv = 32'd7; s_drv = 1'b0; tag_drv = 4'd9; ready_drv = 1'b0; valid_drv = 1'b1;
    @(posedge clk); #1;
    valid_drv = 1'b0;
    waitMainValid(k);
    checkOutput("flush_done_reached", 64'(m_if.out_valid), 64'(1));
    flush_drv = 1'b1; ready_drv = 1'b1;
    @(posedge clk); #1;
    flush_drv = 1'b0;
    checkOutput("flush_done_dropped", 64'(m_if.out_valid), 64'(0));
    checkOutput("flush_done_product_kept", m_if.out_product, 64'd21);
    checkOutput("flush_done_tag_kept", 64'(m_if.out_tag), 64'(9));
    expectNoResult("flush_done_noresult", 12);

    // Flush together with issue
    a_drv = 32'd11; b_drv = 32'd13; tag_drv = 4'd12; valid_drv = 1'b1; flush_drv = 1'b1;
    @(posedge clk); #1;
    valid_drv = 1'b0; flush_drv = 1'b0;
    checkOutput("flush_issue_not_busy", 64'(m_if.busy), 64'(0));
    expectNoResult("flush_issue_noresult", 12);

    // Back-to-back issue with in_valid held
    ta  = '{32'h12345678, 32'hFFFFFFFF, 32'h80000000};
    tb_ = '{32'h9ABCDEF0, 32'h00000003, 32'h00000005};
    ts  = '{1'b0, 1'b1, 1'b1};
    idx = 0; last_acc = -1; nout = 0;
    a_drv = ta[0]; b_drv = tb_[0]; s_drv = ts[0]; tag_drv = 4'd1; ready_drv = 1'b1; valid_drv = 1'b1;
    for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
      acc = m_if.in_ready && valid_drv;
      @(posedge clk); #1;
      if (acc) begin
        q_prod.push_back(refProduct(ta[idx], tb_[idx], ts[idx]));
        q_tag.push_back(4'(idx + 1));
        if (last_acc >= 0) checkOutput("b2b_interval", 64'(cyc - last_acc), 64'(11));
        last_acc = cyc;
        idx++;
        if (idx < 3) begin
          a_drv = ta[idx]; b_drv = tb_[idx]; s_drv = ts[idx]; tag_drv = 4'(idx + 1);
        end else begin
          valid_drv = 1'b0;
        end
      end
      if (m_if.out_valid) begin
        nout++;
        if (q_prod.size() == 0) begin
          checkOutput("b2b_unexpected", 64'(1), 64'(0));
        end else begin
          ep = q_prod.pop_front();
          et = q_tag.pop_front();
          checkOutput("b2b_tag", 64'(m_if.out_tag), 64'(et));
          checkOutput("b2b_product", m_if.out_product, ep);
        end
      end
    end
    checkOutput("b2b_count", 64'(nout), 64'(3));
    valid_drv = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation
    a_drv = 32'hCAFEF00D; b_drv = 32'h00001234; s_drv = 1'b0; tag_drv = 4'd15; valid_drv = 1'b1;
    @(posedge clk); #1;
    valid_drv = 1'b0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 64'(m_if.out_valid), 64'(0));
    checkOutput("areset_product", m_if.out_product, 64'(0));
    checkOutput("areset_tag", 64'(m_if.out_tag), 64'(0));
    checkOutput("areset_busy", 64'(m_if.busy), 64'(0));
    #2 rst_n = 1'b1;
    #1;
    checkOutput("areset_in_ready", 64'(m_if.in_ready), 64'(1));
    expectNoResult("areset_noresult", 12);

    for (int n = 0; n < 60; n++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
